// File: rtl/alu_controller.sv
// Instruction-sequencing controller for the ALU datapath: accepts one 16-bit instruction
// per valid/ready handshake and issues read, load, execute and write-back strobes in order.
module alu_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WREG,
    S_WIMM
  } state_e;

  typedef enum logic [2:0] {
    K_MOV_IMM,
    K_MOV_REG,
    K_ADD,
    K_CMP,
    K_AND,
    K_MVN,
    K_ILLEGAL
  } kind_e;

  localparam logic [1:0] VSEL_C      = 2'b00;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b10;

  // Classifies an instruction word by its opcode[15:13] / op[12:11] pair.
  function automatic kind_e decode(input logic [15:0] w);
    kind_e k;
    case ({w[15:13], w[12:11]})
      5'b110_10: k = K_MOV_IMM;
      5'b110_00: k = K_MOV_REG;
      5'b101_00: k = K_ADD;
      5'b101_01: k = K_CMP;
      5'b101_10: k = K_AND;
      5'b101_11: k = K_MVN;
      default:   k = K_ILLEGAL;
    endcase
    return k;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  kind_e       kind_q, kind_d;
  logic        accept;

  logic        in_ready_q, in_ready_d;
  logic [2:0]  readnum_q, readnum_d;
  logic [2:0]  writenum_q, writenum_d;
  logic        write_q, write_d;
  logic        loada_q, loada_d;
  logic        loadb_q, loadb_d;
  logic        loadc_q, loadc_d;
  logic        loads_q, loads_d;
  logic        asel_q, asel_d;
  logic [1:0]  vsel_q, vsel_d;
  logic [1:0]  aluop_q, aluop_d;
  logic [1:0]  shift_q, shift_d;
  logic [15:0] sximm8_q, sximm8_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;

  assign kind_q = decode(ir_q);
  assign accept = in_valid & in_ready_q;

  // Next state and instruction register.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (kind_q)
          K_MOV_IMM:               state_d = S_WIMM;
          K_MOV_REG, K_MVN:        state_d = S_GETB;
          K_ADD, K_CMP, K_AND:     state_d = S_GETA;
          default:                 state_d = S_IDLE;
        endcase
      end
      S_GETA:  state_d = S_GETB;
      S_GETB:  state_d = S_EXEC;
      S_EXEC:  state_d = (kind_q == K_CMP) ? S_IDLE : S_WREG;
      S_WREG:  state_d = S_IDLE;
      S_WIMM:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs are computed from the upcoming state and IR so that the
  // registered copies line up exactly with the state they belong to.
  assign kind_d = decode(ir_d);

  always_comb begin
    in_ready_d = (state_d == S_IDLE);
    readnum_d  = (state_d == S_GETB) ? ir_d[2:0] : ir_d[10:8];
    writenum_d = (state_d == S_WIMM) ? ir_d[10:8] : ir_d[7:5];
    aluop_d    = ir_d[12:11];
    shift_d    = ir_d[4:3];
    sximm8_d   = {{8{ir_d[7]}}, ir_d[7:0]};
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = VSEL_C;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    case (state_d)
      S_DECODE: begin
        if (kind_d == K_ILLEGAL) begin
          done_d    = 1'b1;
          illegal_d = 1'b1;
        end
      end
      S_GETA: loada_d = 1'b1;
      S_GETB: loadb_d = 1'b1;
      S_EXEC: begin
        if (kind_d == K_CMP) begin
          loads_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          loadc_d = 1'b1;
        end
        // MOV reg and MVN only use B; forcing A to 0 makes ADD pass B through.
        asel_d = (kind_d == K_MOV_REG) || (kind_d == K_MVN);
      end
      S_WREG: begin
        write_d = 1'b1;
        vsel_d  = VSEL_C;
        done_d  = 1'b1;
      end
      S_WIMM: begin
        write_d = 1'b1;
        vsel_d  = VSEL_SXIMM8;
        done_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      in_ready_q <= 1'b1;
      readnum_q  <= '0;
      writenum_q <= '0;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= '0;
      aluop_q    <= '0;
      shift_q    <= '0;
      sximm8_q   <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      in_ready_q <= in_ready_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      asel_q     <= asel_d;
      vsel_q     <= vsel_d;
      aluop_q    <= aluop_d;
      shift_q    <= shift_d;
      sximm8_q   <= sximm8_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
    end
  end

  assign in_ready = in_ready_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign write    = write_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign asel     = asel_q;
  assign bsel     = 1'b0;
  assign vsel     = vsel_q;
  assign ALUop    = aluop_q;
  assign shift    = shift_q;
  assign sximm8   = sximm8_q;
  assign done     = done_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_controller.sv
// Directed bench for alu_controller: per-cycle expected output vectors are queued when an
// instruction is driven and popped one per cycle as the controller steps through it.
module tb_alu_controller;

  typedef struct packed {
    logic        in_ready;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic        done;
    logic        illegal;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] instr;
  logic        in_ready, write, loada, loadb, loadc, loads, asel, bsel, done, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, aluop, shift;
  logic [15:0] sximm8;

  obs_t  obs;
  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  alu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .instr    (instr),
    .in_ready (in_ready),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .vsel     (vsel),
    .ALUop    (aluop),
    .shift    (shift),
    .sximm8   (sximm8),
    .done     (done),
    .illegal  (illegal)
  );

  always_comb begin
    obs          = '0;
    obs.in_ready = in_ready;
    obs.readnum  = readnum;
    obs.writenum = writenum;
    obs.write    = write;
    obs.loada    = loada;
    obs.loadb    = loadb;
    obs.loadc    = loadc;
    obs.loads    = loads;
    obs.asel     = asel;
    obs.bsel     = bsel;
    obs.vsel     = vsel;
    obs.aluop    = aluop;
    obs.shift    = shift;
    obs.sximm8   = sximm8;
    obs.done     = done;
    obs.illegal  = illegal;
  end

  task automatic check(input string tag, input obs_t o, input obs_t e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input obs_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed %h expected none", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  // Advance one clock and compare the oldest queued expectation.
  task automatic step();
    @(posedge clk);
    #1;
    pop_check();
  endtask

  obs_t z, b, e;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    instr    = 16'h0000;
    z          = '0;
    z.in_ready = 1'b1;

    // Reset, then idle.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) push($sformatf("idle_after_reset_%0d", i), z);
    repeat (5) step();

    // MOV R3,#-5
    b = '0; b.readnum = 3'd3; b.writenum = 3'd7; b.aluop = 2'b10; b.shift = 2'b11;
    b.sximm8 = 16'hFFFB;
    instr = 16'hD3FB; in_valid = 1'b1;
    push("movi_c1", b);
    e = b; e.write = 1'b1; e.writenum = 3'd3; e.vsel = 2'b10; e.done = 1'b1; push("movi_c2", e);
    e = b; e.in_ready = 1'b1; push("movi_c3_idle", e);
    step();
    in_valid = 1'b0;
    repeat (2) step();

    // ADD R2,R1,R0,LSL#1
    b = '0; b.readnum = 3'd1; b.writenum = 3'd2; b.aluop = 2'b00; b.shift = 2'b01;
    b.sximm8 = 16'h0048;
    instr = 16'hA148; in_valid = 1'b1;
    push("add_c1", b);
    e = b; e.loada = 1'b1; push("add_c2", e);
    e = b; e.loadb = 1'b1; e.readnum = 3'd0; push("add_c3", e);
    e = b; e.loadc = 1'b1; push("add_c4", e);
    e = b; e.write = 1'b1; e.vsel = 2'b00; e.done = 1'b1; push("add_c5", e);
    e = b; e.in_ready = 1'b1; push("add_c6_idle", e);
    step();
    in_valid = 1'b0;
    repeat (5) step();

    // CMP R4,R5
    b = '0; b.readnum = 3'd4; b.writenum = 3'd0; b.aluop = 2'b01; b.shift = 2'b00;
    b.sximm8 = 16'h0005;
    instr = 16'hAC05; in_valid = 1'b1;
    push("cmp_c1", b);
    e = b; e.loada = 1'b1; push("cmp_c2", e);
    e = b; e.loadb = 1'b1; e.readnum = 3'd5; push("cmp_c3", e);
    e = b; e.loads = 1'b1; e.done = 1'b1; push("cmp_c4", e);
    e = b; e.in_ready = 1'b1; push("cmp_c5_idle", e);
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // MVN R7,R6
    b = '0; b.readnum = 3'd0; b.writenum = 3'd7; b.aluop = 2'b11; b.shift = 2'b00;
    b.sximm8 = 16'hFFE6;
    instr = 16'hB8E6; in_valid = 1'b1;
    push("mvn_c1", b);
    e = b; e.loadb = 1'b1; e.readnum = 3'd6; push("mvn_c2", e);
    e = b; e.loadc = 1'b1; e.asel = 1'b1; push("mvn_c3", e);
    e = b; e.write = 1'b1; e.done = 1'b1; push("mvn_c4", e);
    e = b; e.in_ready = 1'b1; push("mvn_c5_idle", e);
    step();
    in_valid = 1'b0;
    repeat (4) step();

    // Illegal instruction word
    b = '0;
    instr = 16'h0000; in_valid = 1'b1;
    e = b; e.done = 1'b1; e.illegal = 1'b1; push("illegal_c1", e);
    e = b; e.in_ready = 1'b1; push("illegal_c2_idle", e);
    step();
    in_valid = 1'b0;
    step();

    // CMP again, with an ADD held valid the whole time: ir must not change until idle.
    b = '0; b.readnum = 3'd4; b.writenum = 3'd0; b.aluop = 2'b01; b.sximm8 = 16'h0005;
    instr = 16'hAC05; in_valid = 1'b1;
    push("cmp2_c1", b);
    e = b; e.loada = 1'b1; push("cmp2_c2_hold", e);
    e = b; e.loadb = 1'b1; e.readnum = 3'd5; push("cmp2_c3_hold", e);
    e = b; e.loads = 1'b1; e.done = 1'b1; push("cmp2_c4_hold", e);
    e = b; e.in_ready = 1'b1; push("cmp2_c5_idle", e);
    step();
    instr = 16'hA148;
    repeat (4) step();

    b = '0; b.readnum = 3'd1; b.writenum = 3'd2; b.shift = 2'b01; b.sximm8 = 16'h0048;
    push("add2_c1_accepted", b);
    e = b; e.loada = 1'b1; push("add2_c2", e);
    e = b; e.loadb = 1'b1; e.readnum = 3'd0; push("add2_c3", e);
    step();
    in_valid = 1'b0;
    repeat (2) step();

    // Asynchronous reset during ADD cycle 3: strobes drop before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    push("reset_async_mid_add", z);
    pop_check();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) push($sformatf("idle_after_abort_%0d", i), z);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
